drive_arbiter: RTL and testbench
================================

# drive_arbiter

Sequences the robot's motor commands from the mode FSM's outputs. It selects the active drive source (camera tracker, IR remote, or none) from the current mode. It ramps motor duty toward the requested speed and enforces a stop-and-dwell before any change of direction class. Each resulting command/duty pair is handed to the motor link transmitter over a valid/ready handshake. It sits between the mode FSM / camera direction logic and the motor UART transmitter.

## Interface
- `DWELL_CYC`, 2_500_000: stopped cycles (50 ms at 50 MHz) required before a direction-class change.
- `RAMP_DIV`, 50_000: cycles per ramp tick (1 ms).
- `RAMP_STEP`, 16: duty change per ramp tick.
- `IR_TIMEOUT_CYC`, 25_000_000: cycles without `ir_valid` before the IR request is forced to STOP.
- `clk_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-high.
- `mode`  in  2  IDLE=00, CAM=01, IR=10; 11 is treated as IDLE.
- `mode_change`  in  1  one-cycle pulse when the mode FSM changes state.
- `cam_drive`  in  3  camera drive request: STOP 000, LEFT 001, RIGHT 010, SLOW 011, MEDIUM 100, FAST 101.
- `ir_drive`  in  3  IR drive request, same encoding as `cam_drive`.
- `ir_valid`  in  1  one-cycle pulse; latches `ir_drive`.
- `tx_ready`  in  1  motor transmitter can accept a frame.
- `tx_valid`  out  1  frame pending.
- `tx_cmd`  out  3  committed drive command.
- `tx_duty`  out  8  committed duty.
- `active_src`  out  2  00 none, 01 CAM, 10 IR.
- `seq_state`  out  2  HOLD 00, RAMP 01, DOWN 10, DWELL 11.

## Operation
- Request selection:
  - IDLE gives STOP.
  - CAM gives `cam_drive`.
  - IR gives the IR latch. The latch is loaded on `ir_valid`, cleared to STOP when the watchdog reaches `IR_TIMEOUT_CYC`, and cleared when leaving IR mode.
  - Codes 110/111 are treated as STOP.
- Target duty: STOP 0, LEFT/RIGHT 96, SLOW 64, MEDIUM 144, FAST 255.
- Direction class: NONE (STOP), L, R, FWD (SLOW/MEDIUM/FAST).
- Sequencer states:
  - HOLD: duty equals target. A new request in the same class (or from NONE, or with `tx_cmd`=STOP) sets `tx_cmd` to the request and goes to RAMP. A different non-NONE class, or a STOP request, goes to DOWN.
  - RAMP: on each tick, duty moves `RAMP_STEP` toward target and clamps at the target (never overshoots, no 8-bit wrap). Reaching target goes to HOLD. A class change mid-ramp goes to DOWN.
  - DOWN: on each tick, duty decreases by `RAMP_STEP`, saturating at 0. At 0, `tx_cmd` becomes STOP, the dwell counter clears, and the block goes to DWELL.
  - DWELL: counts `DWELL_CYC` cycles, then goes to HOLD. The new request is re-evaluated there, and no stale request is replayed.
- A `mode_change` pulse in any state forces DOWN, or DWELL if duty is already 0.
- Ramp ticks only take effect while `tx_valid`=0. At most one tick is held pending, so every duty step is transmitted.
- Handshake:
  - `tx_valid` rises when committed (cmd, duty) differs from the last accepted frame.
  - The payload stays frozen while `tx_valid`=1.
  - Transfer occurs on a cycle with `tx_valid & tx_ready`. `tx_valid` drops the next cycle unless a new difference exists.
- Reset values: `tx_cmd`=STOP, `tx_duty`=0, `tx_valid`=0, `active_src`=00, `seq_state`=HOLD, IR latch=STOP, all counters 0, last-sent=(STOP,0).

## Timing
- Inputs are registered. A request change reaches the sequencer decision 1 cycle later. The committed cmd/duty update lands the following cycle, and `tx_valid` is asserted the cycle after that.
- Ramp period is exactly `RAMP_DIV` cycles from a free-running divider. The tick is one cycle wide.
- DWELL lasts exactly `DWELL_CYC` cycles. The count starts the cycle after duty reaches 0 with `tx_cmd`=STOP.
- The watchdog restarts on every `ir_valid`. If `ir_valid` arrives in the same cycle as the timeout, the new value wins.
- If `mode_change` and `ir_valid` coincide, `mode_change` has priority for sequencing. The IR latch still loads if the new mode is IR.
- `reset` mid-transfer drops `tx_valid` immediately. The transmitter must tolerate an aborted frame.

## Structure
- Shared package `drive_pkg`: drive-state enum (shared with the mode FSM), mode enum, seq-state enum, duty constants, and class-mapping function.
- One sub-module, `drive_tick_gen`: a parameterised `RAMP_DIV` divider producing a one-cycle tick, with synchronous reset.

## Test plan
All scenarios use `DWELL_CYC`=20, `RAMP_DIV`=4, `RAMP_STEP`=32, `IR_TIMEOUT_CYC`=100, and `tx_ready`=1 unless stated.
- Reset, then mode CAM with `cam_drive`=SLOW: frames (011,32), then (011,64). `seq_state` ends in HOLD.
- SLOW then FAST in CAM: duty goes 64→96→…→224→255 (clamped). There is no DOWN.
- FAST then LEFT: duty ramps down to 0, then frame (000,0), then 20 cycles in DWELL, then frames (001,32)…(001,96).
- Mode IR with one `ir_valid` carrying MEDIUM and no further presses: ramp up to 144. After 100 cycles the latch becomes STOP, duty ramps down, and the final frame is (000,0).
- Hold `tx_ready`=0 for 30 cycles mid-ramp: the payload stays frozen. After release, the duty sequence has no skipped step.
- `mode_change` pulse during RAMP at duty 96: immediate DOWN. The next frames are (…,64), (…,32), (000,0), followed by DWELL.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared drive definitions: command codes, modes, sequencer states, duty table
// and direction-class mapping used by the mode FSM and the drive arbiter.
package drive_pkg;

  typedef enum logic [2:0] {
    DRV_STOP   = 3'd0,
    DRV_LEFT   = 3'd1,
    DRV_RIGHT  = 3'd2,
    DRV_SLOW   = 3'd3,
    DRV_MEDIUM = 3'd4,
    DRV_FAST   = 3'd5
  } drive_t;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_CAM  = 2'd1,
    MODE_IR   = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    SEQ_HOLD  = 2'd0,
    SEQ_RAMP  = 2'd1,
    SEQ_DOWN  = 2'd2,
    SEQ_DWELL = 2'd3
  } seq_t;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_L    = 2'd1,
    CLS_R    = 2'd2,
    CLS_FWD  = 2'd3
  } dir_class_t;

  localparam logic [7:0] DUTY_STOP   = 8'd0;
  localparam logic [7:0] DUTY_TURN   = 8'd96;
  localparam logic [7:0] DUTY_SLOW   = 8'd64;
  localparam logic [7:0] DUTY_MEDIUM = 8'd144;
  localparam logic [7:0] DUTY_FAST   = 8'd255;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_CAM  = 2'b01;
  localparam logic [1:0] SRC_IR   = 2'b10;

  // Unused codes 110/111 collapse to STOP.
  function automatic drive_t drive_decode(input logic [2:0] code);
    case (code)
      3'd1:    return DRV_LEFT;
      3'd2:    return DRV_RIGHT;
      3'd3:    return DRV_SLOW;
      3'd4:    return DRV_MEDIUM;
      3'd5:    return DRV_FAST;
      default: return DRV_STOP;
    endcase
  endfunction

  function automatic dir_class_t drive_class(input drive_t d);
    case (d)
      DRV_LEFT:                        return CLS_L;
      DRV_RIGHT:                       return CLS_R;
      DRV_SLOW, DRV_MEDIUM, DRV_FAST:  return CLS_FWD;
      default:                         return CLS_NONE;
    endcase
  endfunction

  function automatic logic [7:0] drive_duty(input drive_t d);
    case (d)
      DRV_LEFT, DRV_RIGHT: return DUTY_TURN;
      DRV_SLOW:            return DUTY_SLOW;
      DRV_MEDIUM:          return DUTY_MEDIUM;
      DRV_FAST:            return DUTY_FAST;
      default:             return DUTY_STOP;
    endcase
  endfunction

endpackage

// File: rtl/drive_tick_gen.sv
// Free-running divider emitting a one-cycle tick every RAMP_DIV cycles.
module drive_tick_gen #(
  parameter int unsigned RAMP_DIV = 50_000
) (
  input  logic clk_50,
  input  logic reset,
  output logic tick
);

  localparam int unsigned W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(RAMP_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/drive_arbiter.sv
// Selects the drive source, ramps duty toward the request with stop-and-dwell
// on direction-class changes, and hands each (cmd, duty) to the motor link.
module drive_arbiter
  import drive_pkg::*;
#(
  parameter int unsigned DWELL_CYC      = 2_500_000,
  parameter int unsigned RAMP_DIV       = 50_000,
  parameter int unsigned RAMP_STEP      = 16,
  parameter int unsigned IR_TIMEOUT_CYC = 25_000_000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       mode_change,
  input  logic [2:0] cam_drive,
  input  logic [2:0] ir_drive,
  input  logic       ir_valid,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [2:0] tx_cmd,
  output logic [7:0] tx_duty,
  output logic [1:0] active_src,
  output logic [1:0] seq_state
);

  localparam int unsigned DW = $clog2(DWELL_CYC + 1);
  localparam int unsigned WW = $clog2(IR_TIMEOUT_CYC + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
  localparam logic [WW-1:0] WD_MAX     = WW'(IR_TIMEOUT_CYC);
  localparam logic [8:0]    STEP9      = 9'(RAMP_STEP);
  localparam logic [7:0]    STEP8      = STEP9[7:0];

  logic [1:0]    mode_q;
  logic          mode_change_q, ir_valid_q;
  logic [2:0]    cam_q, ir_drive_q;
  drive_t        ir_latch, req, cmd, last_cmd;
  logic [WW-1:0] wd_cnt;
  logic [DW-1:0] dwell_cnt;
  logic [7:0]    duty, last_duty, req_tgt, ramp_duty, down_duty;
  dir_class_t    req_cls, cmd_cls;
  seq_t          state;
  logic          tick, pend, diff, free, step_now;

  drive_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
    .clk_50 (clk_50),
    .reset  (reset),
    .tick   (tick)
  );

  always_ff @(posedge clk_50) begin
    if (reset) begin
      mode_q        <= '0;
      mode_change_q <= 1'b0;
      cam_q         <= '0;
      ir_drive_q    <= '0;
      ir_valid_q    <= 1'b0;
      active_src    <= SRC_NONE;
    end else begin
      mode_q        <= mode;
      mode_change_q <= mode_change;
      cam_q         <= cam_drive;
      ir_drive_q    <= ir_drive;
      ir_valid_q    <= ir_valid;
      case (mode_q)
        MODE_CAM: active_src <= SRC_CAM;
        MODE_IR:  active_src <= SRC_IR;
        default:  active_src <= SRC_NONE;
      endcase
    end
  end

  // A fresh press beats a timeout landing in the same cycle.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      ir_latch <= DRV_STOP;
      wd_cnt   <= '0;
    end else begin
      if (ir_valid_q)            wd_cnt <= '0;
      else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WW'(1);
      if (mode_q != MODE_IR)     ir_latch <= DRV_STOP;
      else if (ir_valid_q)       ir_latch <= drive_decode(ir_drive_q);
      else if (wd_cnt == WD_MAX) ir_latch <= DRV_STOP;
    end
  end

  always_comb begin
    case (mode_q)
      MODE_CAM: req = drive_decode(cam_q);
      MODE_IR:  req = ir_latch;
      default:  req = DRV_STOP;
    endcase
    req_tgt   = drive_duty(req);
    req_cls   = drive_class(req);
    cmd_cls   = drive_class(cmd);
    ramp_duty = req_tgt;
    if (req_tgt > duty) begin
      if ({1'b0, 8'(req_tgt - duty)} > STEP9) ramp_duty = duty + STEP8;
    end else if ({1'b0, 8'(duty - req_tgt)} > STEP9) begin
      ramp_duty = duty - STEP8;
    end
    down_duty = ({1'b0, duty} > STEP9) ? duty - STEP8 : '0;
  end

  // Payload only moves once the previous frame is accepted and idle, so every
  // step reaches the link; one tick is parked while the link is busy.
  assign diff     = (cmd != last_cmd) || (duty != last_duty);
  assign free     = !tx_valid && !diff;
  assign step_now = (tick || pend) && free;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state     <= SEQ_HOLD;
      cmd       <= DRV_STOP;
      duty      <= '0;
      dwell_cnt <= '0;
      pend      <= 1'b0;
    end else begin
      pend <= (tick || pend) && !free;
      if (mode_change_q) begin
        dwell_cnt <= '0;
        state     <= (duty == '0) ? SEQ_DWELL : SEQ_DOWN;
      end else begin
        case (state)
          SEQ_HOLD: begin
            if (req != cmd)
              state <= (req_cls == cmd_cls || cmd == DRV_STOP) ? SEQ_RAMP : SEQ_DOWN;
          end
          SEQ_RAMP: begin
            if (cmd != DRV_STOP && req_cls != cmd_cls) begin
              state <= SEQ_DOWN;
            end else if (cmd == DRV_STOP && req == DRV_STOP) begin
              state <= SEQ_HOLD;
            end else if (step_now) begin
              cmd  <= req;
              duty <= ramp_duty;
              if (ramp_duty == req_tgt) state <= SEQ_HOLD;
            end
          end
          SEQ_DOWN: begin
            if (duty == '0) begin
              if (free) begin
                cmd       <= DRV_STOP;
                dwell_cnt <= '0;
                state     <= SEQ_DWELL;
              end
            end else if (step_now) begin
              duty <= down_duty;
              if (down_duty == '0) begin
                cmd       <= DRV_STOP;
                dwell_cnt <= '0;
                state     <= SEQ_DWELL;
              end
            end
          end
          default: begin
            if (dwell_cnt == DWELL_LAST) state <= SEQ_HOLD;
            else                         dwell_cnt <= dwell_cnt + DW'(1);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      tx_valid  <= 1'b0;
      last_cmd  <= DRV_STOP;
      last_duty <= '0;
    end else if (tx_valid) begin
      if (tx_ready) begin
        tx_valid  <= 1'b0;
        last_cmd  <= cmd;
        last_duty <= duty;
      end
    end else begin
      tx_valid <= diff;
    end
  end

  assign tx_cmd    = cmd;
  assign tx_duty   = duty;
  assign seq_state = state;

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter with short ramp/dwell/timeout parameters.
module tb_drive_arbiter;

  logic       clk_50 = 1'b0;
  logic       reset, mode_change, ir_valid, tx_ready;
  logic [1:0] mode;
  logic [2:0] cam_drive, ir_drive;
  logic       tx_valid;
  logic [2:0] tx_cmd;
  logic [7:0] tx_duty;
  logic [1:0] active_src, seq_state;

  always #10 clk_50 = ~clk_50;

  drive_arbiter #(
    .DWELL_CYC(20), .RAMP_DIV(4), .RAMP_STEP(32), .IR_TIMEOUT_CYC(100)
  ) dut (
    .clk_50(clk_50), .reset(reset), .mode(mode), .mode_change(mode_change),
    .cam_drive(cam_drive), .ir_drive(ir_drive), .ir_valid(ir_valid),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_cmd(tx_cmd),
    .tx_duty(tx_duty), .active_src(active_src), .seq_state(seq_state)
  );

  int n_cmp = 0, n_bad = 0;
  logic [10:0] frames[$];
  int dwell_run = 0, dwell_len = 0;
  bit saw_down = 1'b0;

  always @(negedge clk_50) begin
    if (!reset && tx_valid && tx_ready) frames.push_back({tx_cmd, tx_duty});
    if (seq_state == 2'b10) saw_down = 1'b1;
    if (seq_state == 2'b11) dwell_run++;
    else if (dwell_run != 0) begin dwell_len = dwell_run; dwell_run = 0; end
  end

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (frames.size() < n && c < budget) begin @(negedge clk_50); c++; end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic pulse_mode(input logic [1:0] m);
    mode = m; mode_change = 1'b1;
    @(negedge clk_50);
    mode_change = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; mode = 2'b00; mode_change = 0; cam_drive = 0;
    ir_drive = 0; ir_valid = 0; tx_ready = 1;
    idle(3);
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
    n_cmp++; if (tx_cmd !== 3'd0) begin n_bad++; $display("FAIL reset_cmd: got %0d want 0", tx_cmd); end
    n_cmp++; if (tx_duty !== 8'd0) begin n_bad++; $display("FAIL reset_duty: got %0d want 0", tx_duty); end
    n_cmp++; if (active_src !== 2'b00) begin n_bad++; $display("FAIL reset_src: got %b want 00", active_src); end
    n_cmp++; if (seq_state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", seq_state); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_cam_slow;
    logic [10:0] exp[$];
    logic [10:0] got;
    exp = '{{3'd3, 8'd32}, {3'd3, 8'd64}};
    frames.delete();
    cam_drive = 3'd3;
    pulse_mode(2'b01);
    wait_frames(exp.size(), 200);
    idle(10);
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < frames.size()) ? frames[i] : 11'bx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL cam_slow frame%0d: got (%0d,%0d) want (%0d,%0d)", i, got[10:8], got[7:0], exp[i][10:8], exp[i][7:0]);
      end
    end
    n_cmp++; if (frames.size() !== exp.size()) begin n_bad++; $display("FAIL cam_slow count: got %0d want %0d", frames.size(), exp.size()); end
    n_cmp++; if (seq_state !== 2'b00) begin n_bad++; $display("FAIL cam_slow state: got %b want 00", seq_state); end
    n_cmp++; if (active_src !== 2'b01) begin n_bad++; $display("FAIL cam_slow src: got %b want 01", active_src); end
  endtask

  task automatic test_same_class_ramp;
    logic [10:0] exp[$];
    logic [10:0] got;
    exp = '{{3'd5, 8'd96}, {3'd5, 8'd128}, {3'd5, 8'd160}, {3'd5, 8'd192}, {3'd5, 8'd224}, {3'd5, 8'd255}};
    frames.delete();
    saw_down = 1'b0;
    cam_drive = 3'd5;
    wait_frames(exp.size(), 200);
    idle(10);
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < frames.size()) ? frames[i] : 11'bx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL slow_fast frame%0d: got (%0d,%0d) want (%0d,%0d)", i, got[10:8], got[7:0], exp[i][10:8], exp[i][7:0]);
      end
    end
    n_cmp++; if (frames.size() !== exp.size()) begin n_bad++; $display("FAIL slow_fast count: got %0d want %0d", frames.size(), exp.size()); end
    n_cmp++; if (saw_down !== 1'b0) begin n_bad++; $display("FAIL slow_fast no_down: got %b want 0", saw_down); end
  endtask

  task automatic test_class_change;
    logic [10:0] exp[$];
    logic [10:0] got;
    exp = '{{3'd5, 8'd223}, {3'd5, 8'd191}, {3'd5, 8'd159}, {3'd5, 8'd127}, {3'd5, 8'd95}, {3'd5, 8'd63},
            {3'd5, 8'd31}, {3'd0, 8'd0}, {3'd1, 8'd32}, {3'd1, 8'd64}, {3'd1, 8'd96}};
    frames.delete();
    dwell_len = 0;
    cam_drive = 3'd1;
    wait_frames(exp.size(), 300);
    idle(20);
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < frames.size()) ? frames[i] : 11'bx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL fast_left frame%0d: got (%0d,%0d) want (%0d,%0d)", i, got[10:8], got[7:0], exp[i][10:8], exp[i][7:0]);
      end
    end
    n_cmp++; if (frames.size() !== exp.size()) begin n_bad++; $display("FAIL fast_left count: got %0d want %0d", frames.size(), exp.size()); end
    n_cmp++; if (dwell_len !== 20) begin n_bad++; $display("FAIL fast_left dwell_len: got %0d want 20", dwell_len); end
  endtask

  task automatic test_ir_timeout;
    logic [10:0] exp[$];
    logic [10:0] got;
    exp = '{{3'd1, 8'd64}, {3'd1, 8'd32}, {3'd0, 8'd0},
            {3'd4, 8'd32}, {3'd4, 8'd64}, {3'd4, 8'd96}, {3'd4, 8'd128}, {3'd4, 8'd144},
            {3'd4, 8'd112}, {3'd4, 8'd80}, {3'd4, 8'd48}, {3'd4, 8'd16}, {3'd0, 8'd0}};
    frames.delete();
    ir_drive = 3'd4; ir_valid = 1'b1;
    pulse_mode(2'b10);
    ir_valid = 1'b0; ir_drive = 3'd0;
    wait_frames(exp.size(), 400);
    idle(30);
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < frames.size()) ? frames[i] : 11'bx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL ir_timeout frame%0d: got (%0d,%0d) want (%0d,%0d)", i, got[10:8], got[7:0], exp[i][10:8], exp[i][7:0]);
      end
    end
    n_cmp++; if (frames.size() !== exp.size()) begin n_bad++; $display("FAIL ir_timeout count: got %0d want %0d", frames.size(), exp.size()); end
    n_cmp++; if (active_src !== 2'b10) begin n_bad++; $display("FAIL ir_timeout src: got %b want 10", active_src); end
    n_cmp++; if (seq_state !== 2'b00) begin n_bad++; $display("FAIL ir_timeout state: got %b want 00", seq_state); end
  endtask

  task automatic test_backpressure;
    logic [10:0] exp[$];
    logic [10:0] got, held;
    bit have = 1'b0;
    int frz_bad = 0;
    exp = '{{3'd5, 8'd32}, {3'd5, 8'd64}, {3'd5, 8'd96}, {3'd5, 8'd128},
            {3'd5, 8'd160}, {3'd5, 8'd192}, {3'd5, 8'd224}, {3'd5, 8'd255}};
    frames.delete();
    cam_drive = 3'd5;
    pulse_mode(2'b01);
    wait_frames(2, 200);
    tx_ready = 1'b0;
    repeat (30) begin
      @(negedge clk_50);
      if (tx_valid) begin
        if (!have) begin held = {tx_cmd, tx_duty}; have = 1'b1; end
        else if ({tx_cmd, tx_duty} !== held) frz_bad++;
      end
    end
    n_cmp++; if (have !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b want 1", have); end
    n_cmp++; if (frz_bad !== 0) begin n_bad++; $display("FAIL stall_frozen: got %0d changes want 0", frz_bad); end
    tx_ready = 1'b1;
    wait_frames(exp.size(), 300);
    idle(10);
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < frames.size()) ? frames[i] : 11'bx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL stall frame%0d: got (%0d,%0d) want (%0d,%0d)", i, got[10:8], got[7:0], exp[i][10:8], exp[i][7:0]);
      end
    end
    n_cmp++; if (frames.size() !== exp.size()) begin n_bad++; $display("FAIL stall count: got %0d want %0d", frames.size(), exp.size()); end
  endtask

  task automatic test_mode_change_ramp;
    logic [10:0] exp[$];
    logic [10:0] got;
    bit found = 1'b0;
    int c = 0;
    exp = '{{3'd5, 8'd223}, {3'd5, 8'd191}, {3'd5, 8'd159}, {3'd5, 8'd127},
            {3'd5, 8'd95}, {3'd5, 8'd63}, {3'd5, 8'd31}, {3'd0, 8'd0}};
    frames.delete();
    cam_drive = 3'd0;
    wait_frames(exp.size(), 200);
    idle(30);
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < frames.size()) ? frames[i] : 11'bx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL stop_down frame%0d: got (%0d,%0d) want (%0d,%0d)", i, got[10:8], got[7:0], exp[i][10:8], exp[i][7:0]);
      end
    end
    exp = '{{3'd4, 8'd32}, {3'd4, 8'd64}, {3'd4, 8'd96}, {3'd4, 8'd64}, {3'd4, 8'd32}, {3'd0, 8'd0}};
    frames.delete();
    cam_drive = 3'd4;
    while (!found && c < 200) begin
      @(negedge clk_50); c++;
      if (tx_cmd == 3'd4 && tx_duty == 8'd96) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL mc_reach96: got %b want 1", found); end
    pulse_mode(2'b01);
    wait_frames(exp.size(), 200);
    n_cmp++; if (seq_state !== 2'b11) begin n_bad++; $display("FAIL mc_dwell: got %b want 11", seq_state); end
    idle(5);
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < frames.size()) ? frames[i] : 11'bx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_bad++;
        $display("FAIL mc_ramp frame%0d: got (%0d,%0d) want (%0d,%0d)", i, got[10:8], got[7:0], exp[i][10:8], exp[i][7:0]);
      end
    end
    n_cmp++; if (frames.size() !== exp.size()) begin n_bad++; $display("FAIL mc_ramp count: got %0d want %0d", frames.size(), exp.size()); end
  endtask

  task automatic test_reset_abort;
    int c = 0;
    tx_ready = 1'b0;
    while (tx_valid !== 1'b1 && c < 100) begin @(negedge clk_50); c++; end
    n_cmp++; if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL abort_pending: got %b want 1", tx_valid); end
    reset = 1'b1;
    @(negedge clk_50);
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", tx_valid); end
    n_cmp++; if ({tx_cmd, tx_duty} !== 11'd0) begin n_bad++; $display("FAIL abort_payload: got (%0d,%0d) want (0,0)", tx_cmd, tx_duty); end
    n_cmp++; if (seq_state !== 2'b00) begin n_bad++; $display("FAIL abort_state: got %b want 00", seq_state); end
    reset = 1'b0; tx_ready = 1'b1; mode = 2'b00; cam_drive = 3'd0;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_cam_slow();
    test_same_class_ramp();
    test_class_change();
    test_ir_timeout();
    test_backpressure();
    test_mode_change_ramp();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
